mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between I-cache fill and D-cache fill/writeback requests.
//  One transaction in flight at a time.
//  Arbitration favours D-side. A starvation counter forces an I-side grant after MAX_DWIN consecutive contested D-side grants.
//  Sits between the I/D caches and the memory model in proc_hier.
// PARAMETERS
//  MEM_LAT   4   cycles from mem_rd/mem_wr accepted to mem_rdata valid (>=1)
//  MAX_DWIN  4   consecutive contested D grants before I is forced (>=1)
// PORTS
//  clk        in   1   system clock, posedge
//  rst        in   1   asynchronous, active-high reset
//  ic_req     in   1   I-side read request; held until ic_done
//  ic_addr    in   16  I-side word address; stable while ic_req
//  ic_done    out  1   one-cycle pulse: I transaction complete, ic_rdata valid
//  ic_rdata   out  16  registered read data for I-side
//  dc_req     in   1   D-side request; held until dc_done
//  dc_wr      in   1   1=write, 0=read; stable while dc_req
//  dc_addr    in   16  D-side word address; stable while dc_req
//  dc_wdata   in   16  D-side write data; stable while dc_req
//  dc_done    out  1   one-cycle pulse: D transaction complete (dc_rdata valid if read)
//  dc_rdata   out  16  registered read data for D-side
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_addr   out  16  latched address of granted transaction
//  mem_wdata  out  16  latched write data (D writes only)
//  mem_rdata  in   16  memory read data, valid MEM_LAT cycles after accept
//  mem_stall  in   1   memory cannot accept a strobe this cycle
//  arb_busy   out  1   state != IDLE (perf counting)
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; dwin_cnt=0
//   - all outputs 0, incl. ic_rdata, dc_rdata, mem_addr, mem_wdata
//   - in-flight transaction abandoned; no done pulse
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   - IDLE: sample ic_req/dc_req at posedge.
//     - If any request: latch winner (addr, wr, wdata, side), go to ISSUE.
//     - Else stay IDLE.
//   - ISSUE: drive mem_rd (read) or mem_wr (D write) high.
//     - mem_stall=1: hold ISSUE, strobe stays high.
//     - mem_stall=0: strobe accepted this cycle; load wait counter with MEM_LAT; go to WAIT.
//   - WAIT: strobes low; counter decrements each cycle.
//     - On the cycle counter==1 (the MEM_LAT-th WAIT cycle), capture mem_rdata into granted side's rdata reg (reads only).
//     - Go to RESP.
//   - RESP: granted side's done=1 for exactly one cycle, then IDLE.
//     - Writes pulse dc_done; dc_rdata unchanged.
//  Requester drops req on the edge ending RESP. A req still high in the following IDLE is a new request.
//  Latency, no stall: req sampled in IDLE cycle c -> ISSUE c+1 -> WAIT c+2..c+1+MEM_LAT -> done at cycle c+2+MEM_LAT.
//   - MEM_LAT=4: done 6 cycles after sampling.
//   - Each stall cycle adds 1.
//  Arbitration (IDLE only):
//   - Only D req: grant D.
//   - Only I req: grant I.
//   - Both: grant I if dwin_cnt==MAX_DWIN, else D.
//  dwin_cnt:
//   - +1 (saturating at MAX_DWIN) on a D grant while ic_req=1.
//   - Cleared on any I grant, or on a D grant with ic_req=0.
//   - Width clog2(MAX_DWIN+1).
//  Requests changing in ISSUE/WAIT/RESP are ignored; latched values drive memory.
//  ic_done and dc_done never high in the same cycle; mem_rd and mem_wr never both high.
//  mem_addr and mem_wdata hold the last latched values outside ISSUE.
// TESTING
//  1 Reset:
//    - assert rst mid-WAIT -> all outputs 0 same cycle.
//    - After release, no done pulse; next req served normally.
//  2 Lone I read, addr 0x0040, mem_rdata=0xBEEF, MEM_LAT=4, no stall
//    -> mem_rd 1 cycle with mem_addr=0x0040; ic_done 6 cycles after sample; ic_rdata=0xBEEF.
//  3 D write addr 0x1234, data 0x5A5A, mem_stall=1 for 3 cycles
//    -> mem_wr high 4 cycles; dc_done at cycle 9; dc_rdata unchanged.
//  4 Both req continuously held (re-raised after each done), MAX_DWIN=4
//    -> grant order D,D,D,D,I,D,D,D,D,I; dwin_cnt cleared after each I.
//  5 D req alone 3 times, then both
//    -> dwin_cnt stays 0 (no contention); first contested grant is D.
//  6 Back-to-back: req held one cycle past done -> second transaction starts.
//    - Random stall/req soak: check one-hot strobes, one-hot done, and no done without prior accept.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between I-cache fill and D-cache fill/writeback, one transaction at a time.
// Latency: done MEM_LAT+2 cycles after the request is sampled in IDLE, plus one cycle per mem_stall cycle.
module mem_arbiter #(
    parameter int MEM_LAT  = 4,
    parameter int MAX_DWIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_req,
    input  logic [15:0] ic_addr,
    output logic        ic_done,
    output logic [15:0] ic_rdata,
    input  logic        dc_req,
    input  logic        dc_wr,
    input  logic [15:0] dc_addr,
    input  logic [15:0] dc_wdata,
    output logic        dc_done,
    output logic [15:0] dc_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    output logic        arb_busy
);

    localparam int DW = $clog2(MAX_DWIN + 1);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam logic [DW-1:0] DWIN_MAX = DW'(MAX_DWIN);
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dwin_cnt;
    logic [LW-1:0] wait_cnt;
    logic          sel_i;
    logic          lat_wr;
    logic          grant_i;
    logic          grant_d;

    // D wins contention unless it has already taken MAX_DWIN contested grants in a row
    assign grant_i = ic_req && (!dc_req || (dwin_cnt == DWIN_MAX));
    assign grant_d = dc_req && !grant_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ic_req || dc_req) state_nxt = ISSUE;
            ISSUE:   if (!mem_stall) state_nxt = WAIT;
            WAIT:    if (wait_cnt == LAT_ONE) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_rd   = (state == ISSUE) && !lat_wr;
    assign mem_wr   = (state == ISSUE) && lat_wr;
    assign ic_done  = (state == RESP) && sel_i;
    assign dc_done  = (state == RESP) && !sel_i;
    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwin_cnt  <= '0;
            wait_cnt  <= '0;
            sel_i     <= 1'b0;
            lat_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        sel_i    <= 1'b1;
                        lat_wr   <= 1'b0;
                        mem_addr <= ic_addr;
                        dwin_cnt <= '0;
                    end else if (grant_d) begin
                        sel_i    <= 1'b0;
                        lat_wr   <= dc_wr;
                        mem_addr <= dc_addr;
                        if (dc_wr) mem_wdata <= dc_wdata;
                        if (!ic_req) dwin_cnt <= '0;
                        else if (dwin_cnt != DWIN_MAX) dwin_cnt <= dwin_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!mem_stall) wait_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    // Read data is only guaranteed on the MEM_LAT-th cycle after the accept
                    if ((wait_cnt == LAT_ONE) && !lat_wr) begin
                        if (sel_i) ic_rdata <= mem_rdata;
                        else       dc_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-exact memory model plus expected grant order per scenario.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic        ic_done;
    logic [15:0] ic_rdata;
    logic        dc_req;
    logic        dc_wr;
    logic [15:0] dc_addr;
    logic [15:0] dc_wdata;
    logic        dc_done;
    logic [15:0] dc_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_stall;
    logic        arb_busy;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_DWIN(4)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .arb_busy(arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        side;   // 1 = I-side
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } sb_t;

    sb_t         sb[$];
    int          compared;
    int          mismatched;
    int          pend_cnt;
    logic [15:0] pend_dat;
    logic        accepted;
    logic [15:0] last_dc;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic sb_t mk(input logic side, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata);
        sb_t e;
        e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = mem_val(addr);
        return e;
    endfunction

    function automatic logic [68:0] all_outs();
        return {ic_done, ic_rdata, dc_done, dc_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, arb_busy};
    endfunction

    // Runs the memory model and pops the scoreboard on each done until n transactions complete.
    task automatic drain(input int n, input bit hold, input int stall_first, input bit rnd_stall,
                         output int last_cyc, output int strobe_cyc);
        int  done_cnt;
        int  cyc;
        int  stall_left;
        sb_t e;
        done_cnt   = 0;
        cyc        = 0;
        stall_left = stall_first;
        last_cyc   = -1;
        strobe_cyc = 0;
        while (done_cnt < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                compared++; mismatched++;
                $display("FAIL drain_timeout: %0d of %0d done after %0d cycles", done_cnt, n, cyc);
                sb.delete();
                ic_req = 1'b0; dc_req = 1'b0;
                break;
            end
            compared++;
            if ((mem_rd && mem_wr) !== 1'b0) begin
                mismatched++;
                $display("FAIL strobe_onehot: rd=%b wr=%b, required not both", mem_rd, mem_wr);
            end
            compared++;
            if ((ic_done && dc_done) !== 1'b0) begin
                mismatched++;
                $display("FAIL done_onehot: ic=%b dc=%b, required not both", ic_done, dc_done);
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                mem_rdata = (pend_cnt == 0) ? pend_dat : ~pend_dat;
            end else begin
                mem_rdata = ~pend_dat;
            end
            if (mem_rd || mem_wr) begin
                strobe_cyc++;
                if (stall_left > 0) begin
                    mem_stall = 1'b1;
                    stall_left--;
                end else begin
                    mem_stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (!mem_stall) begin
                    accepted = 1'b1;
                    pend_cnt = MEM_LAT;
                    pend_dat = mem_val(mem_addr);
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL accept_unexpected: addr=%h, required no strobe", mem_addr);
                    end else if (mem_addr !== sb[0].addr || mem_wr !== sb[0].wr ||
                                 (sb[0].wr && mem_wdata !== sb[0].wdata)) begin
                        mismatched++;
                        $display("FAIL accept_fields: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                                 mem_addr, mem_wr, mem_wdata, sb[0].addr, sb[0].wr, sb[0].wdata);
                    end
                end
            end else begin
                mem_stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (ic_done || dc_done) begin
                compared++;
                if (accepted !== 1'b1) begin
                    mismatched++;
                    $display("FAIL done_without_accept: accepted=%b, required 1", accepted);
                end
                accepted = 1'b0;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL done_unexpected: ic_done=%b dc_done=%b, required none", ic_done, dc_done);
                end else begin
                    e = sb.pop_front();
                    if (ic_done !== e.side) begin
                        mismatched++;
                        $display("FAIL grant_side: got I=%b, required I=%b (addr %h)", ic_done, e.side, e.addr);
                    end
                    compared++;
                    if (mem_addr !== e.addr) begin
                        mismatched++;
                        $display("FAIL addr_hold: mem_addr=%h, required %h", mem_addr, e.addr);
                    end
                    compared++;
                    if (e.side) begin
                        if (ic_rdata !== e.rdata) begin
                            mismatched++;
                            $display("FAIL ic_rdata: got %h, required %h", ic_rdata, e.rdata);
                        end
                    end else if (!e.wr) begin
                        if (dc_rdata !== e.rdata) begin
                            mismatched++;
                            $display("FAIL dc_rdata: got %h, required %h", dc_rdata, e.rdata);
                        end
                        last_dc = e.rdata;
                    end else if (dc_rdata !== last_dc) begin
                        mismatched++;
                        $display("FAIL dc_rdata_on_write: got %h, required unchanged %h", dc_rdata, last_dc);
                    end
                end
                done_cnt++;
                last_cyc = cyc;
                if (!hold) begin
                    if (ic_done) ic_req = 1'b0;
                    else         dc_req = 1'b0;
                end
                if (done_cnt == n) begin
                    ic_req = 1'b0;
                    dc_req = 1'b0;
                end
            end
        end
        mem_stall = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        compared++;
        if (all_outs() !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (arb_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: arb_busy=%b, required 0", arb_busy);
        end
    endtask

    task automatic test_lone_i;
        int lc, sc;
        ic_addr = 16'h0040;
        ic_req  = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0000));
        drain(1, 1'b0, 0, 1'b0, lc, sc);
        compared++;
        if (lc !== 6 || sc !== 1) begin
            mismatched++;
            $display("FAIL lone_i_timing: done at %0d strobe %0d cycles, required 6 and 1", lc, sc);
        end
    endtask

    task automatic test_stalled_write;
        int lc, sc;
        @(negedge clk);
        dc_addr  = 16'h1234;
        dc_wdata = 16'h5A5A;
        dc_wr    = 1'b1;
        dc_req   = 1'b1;
        sb.push_back(mk(1'b0, 1'b1, 16'h1234, 16'h5A5A));
        drain(1, 1'b0, 3, 1'b0, lc, sc);
        compared++;
        if (lc !== 9 || sc !== 4) begin
            mismatched++;
            $display("FAIL stalled_write_timing: done at %0d strobe %0d cycles, required 9 and 4", lc, sc);
        end
    endtask

    task automatic test_reset_mid_wait;
        int lc, sc;
        @(negedge clk);
        dc_addr = 16'h0777;
        dc_wr   = 1'b0;
        dc_req  = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (arb_busy !== 1'b1 || mem_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_wait_state: busy=%b rd=%b, required 1 and 0", arb_busy, mem_rd);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (all_outs() !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_wait: got %h, required 0", all_outs());
        end
        dc_req = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        accepted = 1'b0;
        pend_cnt = 0;
        last_dc  = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            compared++;
            if ((ic_done || dc_done) !== 1'b0) begin
                mismatched++;
                $display("FAIL done_after_reset: ic=%b dc=%b, required none", ic_done, dc_done);
            end
        end
        ic_addr = 16'h0100;
        ic_req  = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 16'h0100, 16'h0000));
        drain(1, 1'b0, 0, 1'b0, lc, sc);
        compared++;
        if (lc !== 6) begin
            mismatched++;
            $display("FAIL post_reset_latency: done at %0d, required 6", lc);
        end
    endtask

    task automatic test_contention;
        int lc, sc;
        @(negedge clk);
        ic_addr = 16'h0200;
        dc_addr = 16'h0300;
        dc_wr   = 1'b0;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, 1'b0, 16'h0300, 16'h0000));
            sb.push_back(mk(1'b1, 1'b0, 16'h0200, 16'h0000));
        end
        drain(10, 1'b1, 0, 1'b0, lc, sc);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL contention_left: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_dside_alone;
        int lc, sc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dc_addr = 16'h0400 + 16'(k);
            dc_wr   = 1'b0;
            dc_req  = 1'b1;
            sb.push_back(mk(1'b0, 1'b0, dc_addr, 16'h0000));
            drain(1, 1'b0, 0, 1'b0, lc, sc);
        end
        @(negedge clk);
        ic_addr = 16'h0500;
        dc_addr = 16'h0600;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, 1'b0, 16'h0600, 16'h0000));
        sb.push_back(mk(1'b1, 1'b0, 16'h0500, 16'h0000));
        drain(5, 1'b1, 0, 1'b0, lc, sc);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL dside_left: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int lc1, lc2, sc;
        @(negedge clk);
        ic_addr = 16'h0700;
        ic_req  = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 16'h0700, 16'h0000));
        drain(1, 1'b1, 0, 1'b0, lc1, sc);
        ic_req = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 16'h0700, 16'h0000));
        drain(1, 1'b0, 0, 1'b0, lc2, sc);
        compared++;
        if (lc1 !== 6 || lc2 !== 7) begin
            mismatched++;
            $display("FAIL back_to_back: done at %0d then +%0d, required 6 then +7", lc1, lc2);
        end
    endtask

    task automatic test_soak;
        int lc, sc, pat;
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            pat      = $urandom_range(0, 2);
            ic_addr  = 16'($urandom);
            dc_addr  = 16'($urandom);
            dc_wdata = 16'($urandom);
            dc_wr    = 1'($urandom_range(0, 1));
            ic_req   = (pat != 1);
            dc_req   = (pat != 0);
            if (pat != 0) sb.push_back(mk(1'b0, dc_wr, dc_addr, dc_wdata));
            if (pat != 1) sb.push_back(mk(1'b1, 1'b0, ic_addr, 16'h0000));
            drain((pat == 2) ? 2 : 1, 1'b0, 0, 1'b1, lc, sc);
        end
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL soak_left: %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        pend_cnt   = 0;
        pend_dat   = 16'h0000;
        accepted   = 1'b0;
        last_dc    = 16'h0000;
        rst        = 1'b1;
        ic_req     = 1'b0;
        ic_addr    = 16'h0000;
        dc_req     = 1'b0;
        dc_wr      = 1'b0;
        dc_addr    = 16'h0000;
        dc_wdata   = 16'h0000;
        mem_rdata  = 16'h0000;
        mem_stall  = 1'b0;
        test_reset();
        test_lone_i();
        test_stalled_write();
        test_reset_mid_wait();
        test_contention();
        test_dside_alone();
        test_back_to_back();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
